// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle for rr_mux_arbiter: CH valid/ready source channels and one
// registered valid/ready output with the grant index of the held data.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CH    = 4
);
  localparam int SEL_W = $clog2(CH);

  logic [CH-1:0]       in_valid;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]       in_ready;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;
  logic                out_ready;
  logic [SEL_W-1:0]    out_grant;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_grant
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// CH-channel round-robin select onto one registered valid/ready output stage.
// Define RR_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer).
module rr_mux_arbiter #(
  parameter int WIDTH = 32,
  parameter int CH    = 4
) (
  input logic             clk,
  input logic             rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int SEL_W = $clog2(CH);

  logic             load_en;
  logic             any_valid;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_data;
  logic [CH-1:0]    in_ready_c;
  logic             hit_lo;
  logic [SEL_W-1:0] gnt_lo;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_grant_q, out_grant_d;
`ifndef RR_MUX_FIXED_PRIO_EN
  logic             hit_hi;
  logic [SEL_W-1:0] gnt_hi;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`endif

  assign load_en   = ~out_valid_q | bus.out_ready;
  assign any_valid = |bus.in_valid;

  // Lowest valid index overall; in round-robin mode also the lowest valid
  // index at or above the pointer, which wins when present.
  always_comb begin
    hit_lo = 1'b0;
    gnt_lo = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        hit_lo = 1'b1;
        gnt_lo = SEL_W'(i);
      end
    end
  end

`ifndef RR_MUX_FIXED_PRIO_EN
  always_comb begin
    hit_hi = 1'b0;
    gnt_hi = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (i >= int'(ptr_q))) begin
        hit_hi = 1'b1;
        gnt_hi = SEL_W'(i);
      end
    end
  end

  assign gnt = hit_hi ? gnt_hi : gnt_lo;
`else
  assign gnt = gnt_lo;
`endif

  always_comb begin
    gnt_data   = '0;
    in_ready_c = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data      = bus.in_data[i*WIDTH +: WIDTH];
        in_ready_c[i] = load_en & hit_lo;
      end
    end
  end

  assign bus.in_ready = in_ready_c;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;
`ifndef RR_MUX_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (load_en) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = gnt_data;
        out_grant_d = gnt;
`ifndef RR_MUX_FIXED_PRIO_EN
        ptr_d       = (int'(gnt) == CH - 1) ? '0 : gnt + SEL_W'(1);
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_grant = out_grant_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a distance-based round-robin model.
module tb_rr_mux_arbiter;
  localparam int W  = 32;
  localparam int CH = 4;
`ifdef RR_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(W), .CH(CH)) bus ();
  rr_mux_arbiter_if #(.WIDTH(W), .CH(3))  bus3 ();

  rr_mux_arbiter #(.WIDTH(W), .CH(CH)) dut  (.clk(clk), .rst(rst), .bus(bus));
  rr_mux_arbiter #(.WIDTH(W), .CH(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Winner = valid channel with the smallest cyclic distance from the start index.
  function automatic int rr_pick(input logic [CH-1:0] v, input int start);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = CH;
    for (int i = 0; i < CH; i++) begin
      if (v[i]) begin
        d = (i - start + CH) % CH;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  bit          model_ok = 1'b0;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_grant;
  int          m_ptr;

  always @(negedge clk) begin
    int          pick;
    bit          load;
    logic [CH-1:0] exp_rdy;
    pick    = rr_pick(bus.in_valid, FIXED ? 0 : m_ptr);
    load    = !m_valid || (bus.out_ready === 1'b1);
    exp_rdy = '0;
    if (load && pick >= 0) exp_rdy[pick] = 1'b1;
    if (model_ok) begin
      check("model_out_valid", bus.out_valid, m_valid);
      check("model_out_data",  bus.out_data,  m_data);
      check("model_out_grant", bus.out_grant, m_grant);
      check("model_in_ready",  bus.in_ready,  exp_rdy);
    end
    if (rst) begin
      m_valid  = 1'b0;
      m_data   = '0;
      m_grant  = 0;
      m_ptr    = 0;
      model_ok = 1'b1;
    end else if (model_ok && load) begin
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.in_data[pick*W +: W];
        m_grant = pick;
        m_ptr   = (pick + 1) % CH;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [CH-1:0] acc;
    int            g;
    int            pg;
    rst            = 1'b1;
    bus.in_valid   = '0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus3.in_valid  = '0;
    bus3.in_data   = '0;
    bus3.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_out_data",  bus.out_data,  0);
      check("idle_out_grant", bus.out_grant, 0);
      check("idle_in_ready",  bus.in_ready,  0);
    end

    @(posedge clk); #1;
    bus.in_valid          = 4'b0100;
    bus.in_data[2*W +: W] = 32'hA5A5_0002;
    bus.out_ready         = 1'b1;
    #1 check("single_in_ready", bus.in_ready, 4'b0100);

    @(posedge clk); #1;
    bus.in_valid        = 4'b0001;
    bus.in_data[0 +: W] = 32'h1234_5678;
    #1;
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_data",  bus.out_data,  32'hA5A5_0002);
    check("single_out_grant", bus.out_grant, 2);
    check("wrap_in_ready",    bus.in_ready,  4'b0001);

    @(posedge clk); #1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    check("prerst_out_valid", bus.out_valid, 1);
    check("prerst_out_data",  bus.out_data,  32'h1234_5678);

    @(posedge clk); #1;
    rst           = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_grant", bus.out_grant, 0);
    check("rst_first_gnt", bus.in_ready,  4'b0001);

    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #2;
      g  = FIXED ? 0 : k % 4;
      pg = FIXED ? 0 : (k - 1) % 4;
      check("rr_in_ready",  bus.in_ready,  1 << g);
      check("rr_out_grant", bus.out_grant, pg);
      check("rr_out_data",  bus.out_data,  32'h1000 + pg);
    end

    @(posedge clk); #1;
    bus.in_valid          = 4'b0010;
    bus.in_data[1*W +: W] = 32'hDEAD_BEEF;
    #1 check("bp_load_ready", bus.in_ready, 4'b0010);

    @(posedge clk); #1;
    bus.in_valid          = 4'b1001;
    bus.in_data[0 +: W]   = 32'h0000_0C00;
    bus.in_data[3*W +: W] = 32'h3333_0003;
    bus.out_ready         = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      #1;
      check("bp_hold_data",  bus.out_data,  32'hDEAD_BEEF);
      check("bp_hold_grant", bus.out_grant, 1);
      check("bp_in_ready",   bus.in_ready,  0);
    end

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, FIXED ? 4'b0001 : 4'b1000);
    check("bp_release_data",  bus.out_data, 32'hDEAD_BEEF);

    @(posedge clk); #1;
    bus.in_valid = '0;
    #1;
    check("bp_next_grant", bus.out_grant, FIXED ? 0 : 3);
    check("bp_next_data",  bus.out_data,  FIXED ? 32'h0000_0C00 : 32'h3333_0003);

    // Random traffic; sources keep valid/data until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < CH; i++) begin
        if (!(bus.in_valid[i] && !acc[i])) begin
          bus.in_valid[i]       = ($urandom_range(0, 99) < 45);
          bus.in_data[i*W +: W] = $urandom;
        end
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      rst           = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = '0;
    repeat (3) @(posedge clk);

    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b0;
    bus3.in_valid  = 3'b111;
    bus3.in_data   = {32'h3002, 32'h3001, 32'h3000};
    bus3.out_ready = 1'b1;
    #1 check("ch3_first_ready", bus3.in_ready, 3'b001);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #2;
      g  = FIXED ? 0 : k % 3;
      pg = FIXED ? 0 : (k - 1) % 3;
      check("ch3_in_ready",  bus3.in_ready,  1 << g);
      check("ch3_out_grant", bus3.out_grant, pg);
      check("ch3_out_data",  bus3.out_data,  32'h3000 + pg);
      check("ch3_grant_lt3", (bus3.out_grant < 2'd3), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised N-channel successor to the datapath 2:1 select mux.
- Selects one of CH valid/ready source channels onto a single registered output with valid/ready handshake.
- Arbitration is round-robin, so simultaneous requesters (e.g. instruction fetch vs. load/store on the shared memory port) are served fairly.
- One output register stage gives 1-cycle latency and full throughput (one transfer per cycle when out_ready is held high).

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- CH, 4, number of input channels; any value ≥2, power of two not required.
- SEL_W, $clog2(CH), width of grant index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  CH  bit i set = channel i presents data.
- in_data  input  CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_ready  output  CH  bit i set = channel i transfer accepted this cycle.
- out_valid  output  1  output register holds valid data.
- out_data  output  WIDTH  registered selected data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_grant  output  SEL_W  index of the channel whose data sits in the output register.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst.
- Reset values:
  - out_valid=0, out_data=0, out_grant=0.
  - Round-robin pointer ptr=0.
  - in_ready is combinational and =0 while out_valid=0 and in_valid=0.
- load_en = ~out_valid | out_ready (output register empty or draining this cycle).
- Arbitration (combinational):
  - Starting from index ptr, scan ptr, ptr+1, … CH-1, 0, … ptr-1.
  - First i with in_valid[i]=1 is gnt.
  - No valid → no grant.
- in_ready[i] = load_en & any_valid & (gnt==i). At most one bit is set (one-hot or zero).
- On a cycle with load_en & any_valid:
  - out_data <= in_data[gnt], out_grant <= gnt, out_valid <= 1.
  - ptr <= (gnt==CH-1) ? 0 : gnt+1.
- On a cycle with load_en & ~any_valid:
  - out_valid <= 0.
  - out_data and out_grant hold their last value; ptr holds.
- On a cycle with out_valid & ~out_ready:
  - All registers hold.
  - in_ready = 0 for every channel, so no source transfer is lost.
- Latency: input handshake in cycle t gives out_valid=1 with that data in cycle t+1.
- Throughput: with out_ready held high, one transfer per cycle.
- Simultaneous drain and load (out_valid & out_ready & any_valid): output is replaced in the same edge; no bubble.
- Fairness: a channel holding in_valid waits at most CH-1 accepted transfers before it is granted.
- Sources must hold in_valid and in_data stable until in_ready. The block does not check this.
- Wrap-around: ptr wraps from CH-1 to 0, including for non-power-of-two CH. Grant indices ≥CH never occur.
- Reset mid-operation: any pending output is discarded without handshake; state returns to reset values on the next edge.
- Out-of-reset order: channel 0 has first priority, matching the 2:1 mux default of selecting input a when s=0.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest valid index always wins.
  - ptr is removed (not synthesised), and no fairness guarantee applies.
  - All handshake, latency and reset rules are unchanged.
- Undefined (default): round-robin arbitration as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all in_valid=0 for 5 cycles → out_valid=0, out_data=0, out_grant=0, in_ready=0000 throughout.
- Single source: in_valid=0100, in_data[2]=32'hA5A5_0002, out_ready=1 → in_ready=0100 the same cycle; next cycle out_valid=1, out_data=32'hA5A5_0002, out_grant=2.
- Round-robin:
  - Stimulus: all four channels valid continuously, in_data[i]=32'h1000+i, out_ready=1.
  - Default build: grants 0,1,2,3,0,1 on consecutive cycles; out_data follows 32'h1000…32'h1003 with 1-cycle lag.
  - With RR_MUX_FIXED_PRIO_EN: grant stays 0 every cycle.
- Backpressure:
  - Output holds 32'hDEAD_BEEF (channel 1), out_ready=0 for 3 cycles while channels 0 and 3 are valid.
  - Required: out_data unchanged, in_ready=0000 for those 3 cycles.
  - out_ready then rises: same-cycle in_ready=0100? No — in_ready=1000 (ptr=2, so channel 3 wins); the next cycle loads channel 3.
- Mid-operation reset: out_valid=1 with out_data=32'h1234_5678, assert rst one cycle → next cycle out_valid=0, out_grant=0; the first grant afterwards goes to the lowest valid channel.
- Non-power-of-two: CH=3, all valid, out_ready=1 → grants 0,1,2,0,1; out_grant never reads 3.
